// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART TX byte path among N_REQ requesters
// Each packet is a channel-ID header byte followed by the locked lane's data bytes.
module uart_tx_arbiter #(
   parameter int N_REQ = 4,
   parameter logic [7:0] ID_BASE = 8'hA0,
   parameter int MAX_PKT = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [8*N_REQ-1:0]         req_data,
   input  logic [N_REQ-1:0]           req_last,
   output logic [N_REQ-1:0]           req_ready,
   output logic [7:0]                 tx_data,
   output logic                       tx_valid,
   input  logic                       tx_ready,
   output logic [$clog2(N_REQ)-1:0]   grant_id,
   output logic                       busy,
   output logic                       trunc
);
   localparam int GW = $clog2(N_REQ);
   localparam int CW = $clog2(MAX_PKT + 1);
   typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
   state_t state_q, state_d;
   logic [GW-1:0] grant_id_q, grant_id_d, last_grant_q, last_grant_d, pick;
   logic [CW-1:0] cnt_q, cnt_d;
   logic busy_q, busy_d, trunc_q, trunc_d;
   logic lane_v, lane_l;
   logic [7:0] lane_d;
   always_comb begin
      state_d = state_q;
      grant_id_d = grant_id_q;
      last_grant_d = last_grant_q;
      cnt_d = cnt_q;
      trunc_d = 1'b0;
      tx_valid = 1'b0;
      tx_data = 8'h00;
      req_ready = '0;
      lane_v = req_valid[grant_id_q];
      lane_l = req_last[grant_id_q];
      lane_d = req_data[8*grant_id_q +: 8];
      pick = last_grant_q;
      // descending scan so the nearest lane after last_grant wins
      for (int k = N_REQ; k >= 1; k--)
         if (req_valid[(int'(last_grant_q) + k) % N_REQ]) pick = GW'((int'(last_grant_q) + k) % N_REQ);
      if (state_q == IDLE) begin
         if (|req_valid) begin
            grant_id_d = pick;
            cnt_d = '0;
            state_d = HDR;
         end
      end else if (state_q == HDR) begin
         tx_valid = 1'b1;
         tx_data = ID_BASE + 8'(grant_id_q);
         if (tx_ready) state_d = DATA;
      end else begin
         tx_valid = lane_v;
         tx_data = lane_v ? lane_d : 8'h00;
         req_ready[grant_id_q] = tx_ready;
         if (lane_v && tx_ready) begin
            cnt_d = cnt_q + 1'b1;
            if (lane_l || cnt_q == CW'(MAX_PKT - 1)) begin
               last_grant_d = grant_id_q;
               state_d = IDLE;
               trunc_d = !lane_l;
            end
         end
      end
      busy_d = state_d != IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q <= IDLE;
         grant_id_q <= '0;
         last_grant_q <= GW'(N_REQ - 1);
         cnt_q <= '0;
         busy_q <= 1'b0;
         trunc_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_id_q <= grant_id_d;
         last_grant_q <= last_grant_d;
         cnt_q <= cnt_d;
         busy_q <= busy_d;
         trunc_q <= trunc_d;
      end
   end
   assign grant_id = grant_id_q;
   assign busy = busy_q;
   assign trunc = trunc_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of header/data framing, round-robin, truncation, stalls, reset
module tb_uart_tx_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   logic [3:0] req_valid, req_last, req_ready;
   logic [31:0] req_data;
   logic [7:0] tx_data;
   logic tx_valid, tx_ready, busy, trunc;
   logic [1:0] grant_id;
   int checks = 0;
   int errors = 0;
   uart_tx_arbiter dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .grant_id(grant_id), .busy(busy), .trunc(trunc)
   );
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic set_lane(input int i, input logic v, input logic [7:0] d, input logic l);
      req_valid[i] = v;
      req_data[8*i +: 8] = d;
      req_last[i] = l;
   endtask
   task automatic chk_idle(input string tag);
      chk({tag, " busy"}, busy, 0);
      chk({tag, " tx_valid"}, tx_valid, 0);
      chk({tag, " tx_data"}, tx_data, 0);
      chk({tag, " req_ready"}, req_ready, 0);
   endtask
   task automatic do_reset();
      rst_n = 1'b1;
      tick();
      tick();
      rst_n = 1'b0;
   endtask
   initial begin
      req_valid = '0;
      req_last = '0;
      req_data = '0;
      tx_ready = 1'b1;
      do_reset();
      #1;
      chk_idle("reset");
      chk("reset grant_id", grant_id, 0);
      chk("reset trunc", trunc, 0);
      // 1: lane 1 three-byte packet
      set_lane(1, 1, 8'h11, 0);
      #1;
      chk("t1 idle tx_valid", tx_valid, 0);
      tick();
      chk("t1 hdr busy", busy, 1);
      chk("t1 hdr grant", grant_id, 1);
      chk("t1 hdr tx_valid", tx_valid, 1);
      chk("t1 hdr tx_data", tx_data, 8'hA1);
      chk("t1 hdr req_ready", req_ready, 0);
      tick();
      chk("t1 d0 tx_data", tx_data, 8'h11);
      chk("t1 d0 req_ready", req_ready, 4'b0010);
      tick();
      set_lane(1, 1, 8'h22, 0);
      #1;
      chk("t1 d1 tx_data", tx_data, 8'h22);
      chk("t1 d1 busy", busy, 1);
      tick();
      set_lane(1, 1, 8'h33, 1);
      #1;
      chk("t1 d2 tx_data", tx_data, 8'h33);
      chk("t1 d2 busy", busy, 1);
      tick();
      set_lane(1, 0, 8'h00, 0);
      #1;
      chk_idle("t1 end");
      chk("t1 end trunc", trunc, 0);
      // 2: lanes 0 and 2 alternate after reset
      do_reset();
      set_lane(0, 1, 8'h50, 1);
      set_lane(2, 1, 8'h52, 1);
      for (int p = 0; p < 4; p++) begin
         tick();
         chk("t2 hdr tx_data", tx_data, (p % 2) ? 8'hA2 : 8'hA0);
         tick();
         chk("t2 data tx_data", tx_data, (p % 2) ? 8'h52 : 8'h50);
         chk("t2 data req_ready", req_ready, (p % 2) ? 4'b0100 : 4'b0001);
         tick();
         if (p == 3) begin
            set_lane(0, 0, 8'h00, 0);
            set_lane(2, 0, 8'h00, 0);
         end
         #1;
         chk("t2 gap tx_valid", tx_valid, 0);
         chk("t2 gap busy", busy, 0);
      end
      // 3: lane 3 streams 20 bytes, truncated at 16
      set_lane(3, 1, 8'h30, 0);
      tick();
      chk("t3 hdr tx_data", tx_data, 8'hA3);
      tick();
      for (int b = 0; b < 16; b++) begin
         set_lane(3, 1, 8'(8'h30 + b), 0);
         #1;
         chk("t3 a tx_data", tx_data, 8'h30 + b);
         chk("t3 a trunc", trunc, 0);
         tick();
      end
      chk("t3 trunc pulse", trunc, 1);
      chk("t3 trunc tx_valid", tx_valid, 0);
      chk("t3 trunc busy", busy, 0);
      set_lane(3, 1, 8'h40, 0);
      tick();
      chk("t3 hdr2 trunc", trunc, 0);
      chk("t3 hdr2 tx_data", tx_data, 8'hA3);
      tick();
      for (int b = 0; b < 4; b++) begin
         set_lane(3, 1, 8'(8'h40 + b), b == 3);
         #1;
         chk("t3 b tx_data", tx_data, 8'h40 + b);
         tick();
      end
      set_lane(3, 0, 8'h00, 0);
      #1;
      chk_idle("t3 end");
      chk("t3 end trunc", trunc, 0);
      // 4: tx_ready stalls in HDR and DATA on lane 2
      set_lane(2, 1, 8'h61, 0);
      tx_ready = 1'b0;
      tick();
      for (int c = 0; c < 5; c++) begin
         chk("t4 hdr tx_valid", tx_valid, 1);
         chk("t4 hdr tx_data", tx_data, 8'hA2);
         chk("t4 hdr req_ready", req_ready, 0);
         tick();
      end
      tx_ready = 1'b1;
      #1;
      chk("t4 hdr go tx_data", tx_data, 8'hA2);
      tick();
      tx_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("t4 data tx_valid", tx_valid, 1);
         chk("t4 data tx_data", tx_data, 8'h61);
         chk("t4 data req_ready", req_ready, 0);
         tick();
      end
      tx_ready = 1'b1;
      #1;
      chk("t4 data go req_ready", req_ready, 4'b0100);
      tick();
      set_lane(2, 1, 8'h62, 1);
      #1;
      chk("t4 d1 tx_data", tx_data, 8'h62);
      tick();
      set_lane(2, 0, 8'h00, 0);
      #1;
      chk("t4 end busy", busy, 0);
      // 5: lane 3 gaps mid-packet while lane 0 waits
      set_lane(3, 1, 8'h71, 0);
      tick();
      chk("t5 hdr grant", grant_id, 3);
      set_lane(0, 1, 8'h01, 1);
      tick();
      chk("t5 d0 tx_data", tx_data, 8'h71);
      tick();
      set_lane(3, 1, 8'h72, 0);
      #1;
      chk("t5 d1 tx_data", tx_data, 8'h72);
      tick();
      set_lane(3, 0, 8'h00, 0);
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("t5 gap tx_valid", tx_valid, 0);
         chk("t5 gap tx_data", tx_data, 0);
         chk("t5 gap grant", grant_id, 3);
         chk("t5 gap busy", busy, 1);
         chk("t5 gap req_ready", req_ready, 4'b1000);
         tick();
      end
      set_lane(3, 1, 8'h73, 1);
      #1;
      chk("t5 d2 tx_data", tx_data, 8'h73);
      chk("t5 d2 grant", grant_id, 3);
      tick();
      set_lane(3, 0, 8'h00, 0);
      #1;
      chk("t5 end busy", busy, 0);
      tick();
      chk("t5 l0 grant", grant_id, 0);
      chk("t5 l0 hdr", tx_data, 8'hA0);
      tick();
      chk("t5 l0 data", tx_data, 8'h01);
      tick();
      set_lane(0, 0, 8'h00, 0);
      // 6: reset mid-DATA on lane 2
      set_lane(2, 1, 8'h81, 0);
      tick();
      chk("t6 hdr grant", grant_id, 2);
      tick();
      chk("t6 d0 tx_data", tx_data, 8'h81);
      tick();
      set_lane(2, 1, 8'h82, 0);
      tick();
      set_lane(2, 1, 8'h83, 0);
      #1;
      chk("t6 d2 tx_data", tx_data, 8'h83);
      rst_n = 1'b1;
      tick();
      rst_n = 1'b0;
      set_lane(0, 1, 8'h90, 1);
      #1;
      chk_idle("t6 rst");
      chk("t6 rst grant", grant_id, 0);
      chk("t6 rst trunc", trunc, 0);
      tick();
      chk("t6 regrant grant", grant_id, 0);
      chk("t6 regrant hdr", tx_data, 8'hA0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmit path (TX FIFO / `uart_tx` serializer) between `N_REQ` byte-stream requesters. It grants one requester at a time and, for each packet, emits one channel-ID header byte followed by that requester's data bytes until `req_last`. The grant stays locked for the whole packet, so the far-end receiver can demultiplex the stream by header. It sits between the requesters and the TX datapath and drives the byte valid/ready handshake in place of a single source.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `ID_BASE`, default 8'hA0: header byte value is `ID_BASE + grant index` (8-bit, wraps mod 256).
- `MAX_PKT`, default 16: maximum data bytes per packet, header excluded (1..255).
- `clk` input 1: single clock, all logic on rising edge.
- `rst_n` input 1: reset, synchronous and active-high (1 = reset).
- `req_valid` input `N_REQ`: requester i has a byte on its lane.
- `req_data` input `8*N_REQ`: requester i byte in bits [8i+7:8i].
- `req_last` input `N_REQ`: the byte on lane i is the final byte of its packet.
- `req_ready` output `N_REQ`: lane i byte accepted this cycle when `req_valid[i] && req_ready[i]`.
- `tx_data` output 8: byte toward the TX datapath.
- `tx_valid` output 1: `tx_data` is valid.
- `tx_ready` input 1: TX datapath accepts; a transfer occurs when `tx_valid && tx_ready`.
- `grant_id` output `$clog2(N_REQ)`: index of the locked requester (valid while `busy`).
- `busy` output 1: a packet is in progress (state HDR or DATA).
- `trunc` output 1: one-cycle pulse when a packet is force-ended at `MAX_PKT`.

## Operation
- FSM states: IDLE, HDR, DATA.
- **IDLE**
  - `tx_valid`=0 and all `req_ready`=0.
  - If any `req_valid` is set, pick the first set bit searching upward, circularly, from `last_grant+1`.
  - Register the pick into `grant_id`, clear the byte counter `cnt`, and go to HDR.
- **HDR**
  - `tx_valid`=1, `tx_data`=`ID_BASE+grant_id`, `req_ready`=0.
  - On a transfer, go to DATA.
- **DATA**
  - Combinational passthrough for lane g=`grant_id`: `tx_valid`=`req_valid[g]`, `tx_data`=lane g, `req_ready[g]`=`tx_ready`.
  - All other `req_ready` bits are 0.
  - On each transfer, `cnt` increments (width `$clog2(MAX_PKT+1)`).
  - If `req_last[g]` is set, or `cnt==MAX_PKT-1` at the transfer: set `last_grant<=g` and go to IDLE.
  - If the end is due to `cnt` and `req_last[g]`=0, pulse `trunc` the following cycle. The requester's remaining bytes form a new packet on a later grant.
- The lock is held while the granted lane deasserts `req_valid`; there is no timeout, and `tx_valid` stays 0 for those cycles.
- Other lanes' `req_valid` changes never affect an active packet.
- Fairness: after lane g finishes, lane g has the lowest priority for the next pick.
- `tx_data` is 8'h00 whenever `tx_valid`=0.

## Timing
- Reset values:
  - state IDLE, `last_grant`=`N_REQ-1` (lane 0 first priority), `cnt`=0.
  - `grant_id`=0, `busy`=0, `trunc`=0, `tx_valid`=0, `tx_data`=0, `req_ready`=0.
- Latency: `req_valid` seen in IDLE at edge k gives HDR with `tx_valid`=1 from cycle k+1.
- With `tx_ready` held high, a packet of n bytes occupies n+1 transfer cycles plus 1 IDLE arbitration cycle, so there is one idle cycle between packets.
- `busy` is registered: 1 in HDR and DATA, 0 in IDLE.
- `tx_valid` must not drop in HDR once raised until the transfer; `tx_data` is stable while `tx_valid && !tx_ready`.
- `trunc` is high exactly one cycle, coinciding with the first IDLE cycle.
- Reset asserted mid-packet:
  - From the next cycle, state is IDLE and all outputs are at reset values.
  - A partially sent packet is abandoned (no closing byte).
- A `req_last` on lane g, presented while `cnt==MAX_PKT-1`, ends the packet normally (`trunc`=0).

## Test plan
1. Lane 1 only sends 8'h11, 8'h22, 8'h33 (last on 8'h33), with `tx_ready`=1 → TX sees A1, 11, 22, 33. `grant_id`=1, `busy` is high for 4 cycles, `trunc`=0.
2. Lanes 0 and 2 both request one-byte packets continuously after reset → headers alternate A0, A2, A0, A2. There is one idle cycle between packets.
3. Lane 3 streams 20 bytes with no `req_last` (`MAX_PKT`=16) → A3 plus 16 bytes, then a `trunc` pulse. Next comes A3 plus the remaining 4 bytes, if no other lane is requesting.
4. `tx_ready`=0 for 5 cycles during HDR, then during DATA → `tx_valid` stays high and `tx_data` is stable. `req_ready[g]`=0 and no byte is lost or duplicated.
5. The granted lane drops `req_valid` for 3 cycles mid-packet while lane 0 requests → `tx_valid`=0 and the grant is unchanged. The packet resumes and completes before lane 0 is granted.
6. `rst_n`=1 for one cycle in DATA after 2 bytes → the next cycle has IDLE, `busy`=0, `tx_valid`=0. A subsequent request is granted with lane 0 first priority.
